alu_subtractor_seq: RTL

//  Multi-cycle 64-bit two's-complement subtractor: diff = a - b, with borrow, signed overflow, zero.

---
 rtl/alu_subtractor_seq_if.sv | 43 ++++
 rtl/alu_subtractor_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_subtractor_seq_if.sv
// Handshake bundle for the multi-cycle subtractor: operand channel in, result channel out.
interface alu_subtractor_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  // Execute-stage side: offers operands, consumes results
  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  borrow,
    input  overflow,
    input  zero
  );

  // Subtractor side: accepts operands, produces results
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output borrow,
    output overflow,
    output zero
  );
endinterface

// File: rtl/alu_subtractor_seq.sv
// Multi-cycle two's-complement subtractor: diff = a - b computed as a + ~b + 1,
// CHUNK bits per cycle, so the long carry chain is split over WIDTH/CHUNK cycles.
// Operands are taken in IDLE, chunks are summed in RUN, and the result with its
// borrow/overflow/zero flags is held in DONE until the consumer takes it.
module alu_subtractor_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input logic                 clk,
  input logic                 reset,
  alu_subtractor_seq_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] nb_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             borrow_reg;
  logic             overflow_reg;
  logic             zero_reg;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             last_chunk;

  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] nb_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             c_out;
  logic             c_in_msb;

  // State register; reset drops any operation in flight back to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; in_ready is held low while reset is asserted
  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    last_chunk  = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = ~reset;
        if (bus.in_valid && !reset) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == LAST) begin
          last_chunk = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept = in_ready_c & bus.in_valid;

  // One chunk of a + ~b + carry; the MSB carry-in is recovered from the sum bit
  always_comb begin
    base      = int'(count) * CHUNK;
    a_chunk   = a_reg[base +: CHUNK];
    nb_chunk  = nb_reg[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, nb_chunk} + {{CHUNK{1'b0}}, carry};
    s_chunk   = chunk_sum[CHUNK-1:0];
    c_out     = chunk_sum[CHUNK];
    c_in_msb  = a_chunk[CHUNK-1] ^ nb_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
    diff_next = diff_reg;
    diff_next[base +: CHUNK] = s_chunk;
  end

  // Operand capture on accept, then chunk-by-chunk accumulation of diff and carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      nb_reg   <= '0;
      diff_reg <= '0;
      carry    <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      a_reg  <= bus.a;
      nb_reg <= ~bus.b;
      carry  <= 1'b1;
      count  <= '0;
    end else if (state == RUN) begin
      diff_reg <= diff_next;
      carry    <= c_out;
      count    <= last_chunk ? '0 : count + CW'(1);
    end
  end

  // Flags are registered only on entry to DONE and otherwise keep their last values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      borrow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (state == RUN && last_chunk) begin
      borrow_reg   <= ~c_out;
      overflow_reg <= c_in_msb ^ c_out;
      zero_reg     <= (diff_next == '0);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_reg;
  assign bus.borrow    = borrow_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;

endmodule
